// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns MIPS byte/half/word and unaligned
// LWL/LWR/SWL/SWR accesses into aligned big-endian 32-bit word accesses.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req_valid,
    input  logic [3:0]  Req_op,
    input  logic [31:0] Req_addr,
    input  logic [31:0] Req_wdata,
    input  logic [31:0] Req_rt_old,
    output logic        Ready,
    output logic        Mem_Wr_en,
    output logic [31:0] Data_Addr,
    output logic [31:0] Din,
    input  logic [31:0] Dout,
    output logic        Load_valid,
    output logic [31:0] Load_data,
    output logic        Addr_err
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_LWL = 4'd6;
    localparam logic [3:0] OP_LWR = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state_q, state_d;
    logic [31:0] old_q, old_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        load_valid_q, load_valid_d;
    logic [31:0] load_data_q, load_data_d;
    logic        addr_err_q, addr_err_d;

    logic [1:0]  off;
    logic [4:0]  sh_l, sh_r, shq_l, shq_r;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] merged;

    // Byte o lives at bits [31-8o -: 8]; right-shifting by 8(3-o) brings it to the bottom.
    assign off    = Req_addr[1:0];
    assign sh_l   = {off, 3'b000};
    assign sh_r   = {~off, 3'b000};
    assign shq_l  = {off_q, 3'b000};
    assign shq_r  = {~off_q, 3'b000};
    assign byte_v = 8'(Dout >> sh_r);
    assign half_v = off[1] ? Dout[15:0] : Dout[31:16];

    // Write-back word for the second half of a read-modify-write.
    always_comb begin
        merged = old_q;
        case (op_q)
            OP_SB:  merged = (old_q & ~(32'hFF00_0000 >> shq_l)) | ({wdata_q[7:0], 24'h0} >> shq_l);
            OP_SH:  merged = (old_q & ~(32'hFFFF_0000 >> shq_l)) | ({wdata_q[15:0], 16'h0} >> shq_l);
            OP_SWL: merged = (old_q & ~(32'hFFFF_FFFF >> shq_l)) | (wdata_q >> shq_l);
            OP_SWR: merged = (old_q & ~(32'hFFFF_FFFF << shq_r)) | (wdata_q << shq_r);
            default: merged = old_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        old_d        = old_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        off_d        = off_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        addr_err_d   = 1'b0;
        Ready        = 1'b0;
        Mem_Wr_en    = 1'b0;
        Data_Addr    = {Req_addr[31:2], 2'b00};
        Din          = Req_wdata;

        case (state_q)
            IDLE: begin
                Ready = 1'b1;
                if (Req_valid) begin
                    case (Req_op)
                        OP_LB: begin
                            load_valid_d = 1'b1;
                            load_data_d  = {{24{byte_v[7]}}, byte_v};
                        end
                        OP_LBU: begin
                            load_valid_d = 1'b1;
                            load_data_d  = {24'h0, byte_v};
                        end
                        OP_LH, OP_LHU: begin
                            if (off[0]) begin
                                addr_err_d = 1'b1;
                            end else begin
                                load_valid_d = 1'b1;
                                load_data_d  = {{16{half_v[15] && (Req_op == OP_LH)}}, half_v};
                            end
                        end
                        OP_LW: begin
                            if (off != 2'd0) begin
                                addr_err_d = 1'b1;
                            end else begin
                                load_valid_d = 1'b1;
                                load_data_d  = Dout;
                            end
                        end
                        OP_LWL: begin
                            load_valid_d = 1'b1;
                            load_data_d  = (Dout << sh_l) | (Req_rt_old & ~(32'hFFFF_FFFF << sh_l));
                        end
                        OP_LWR: begin
                            load_valid_d = 1'b1;
                            load_data_d  = (Dout >> sh_r) | (Req_rt_old & ~(32'hFFFF_FFFF >> sh_r));
                        end
                        OP_SW: begin
                            if (off != 2'd0) addr_err_d = 1'b1;
                            else             Mem_Wr_en  = 1'b1;
                        end
                        OP_SB, OP_SH, OP_SWL, OP_SWR: begin
                            if ((Req_op == OP_SH) && off[0]) begin
                                addr_err_d = 1'b1;
                            end else begin
                                old_d   = Dout;
                                addr_d  = Req_addr[31:2];
                                wdata_d = Req_wdata;
                                op_d    = Req_op;
                                off_d   = off;
                                state_d = RMW_WR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RMW_WR: begin
                Mem_Wr_en = 1'b1;
                Data_Addr = {addr_q, 2'b00};
                Din       = merged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A store caught by reset must not reach memory.
        if (reset) Mem_Wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            old_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= '0;
            off_q        <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            old_q        <= old_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            off_q        <= off_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign Load_valid = load_valid_q;
    assign Load_data  = load_data_q;
    assign Addr_err   = addr_err_q;

endmodule
